// File: rtl/rvenc_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// opcode constants, FSM state encoding, FIFO entry layout and helpers.
// Optional feature macro: RVENC_LI_SPLIT_EN (enables the LUI+ADDI split of
// wide load-immediate requests; when undefined the SPLIT state does not exist).
package rvenc_pkg;

  // Request format codes as presented on req_fmt
  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [4:0] REG_X0  = 5'd0;

`ifdef RVENC_LI_SPLIT_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } state_e;
`endif

  // One FIFO slot: end-of-request marker plus the encoded word
  typedef struct packed {
    logic        last;
    logic [31:0] inst;
  } fifo_entry_t;

  // True when imm is representable as a signed value of 'bits' bits,
  // i.e. everything from bit (bits-1) upward is a pure sign extension.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic signed [31:0] s;
    s = $signed(imm) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

  // I-type word: imm[11:0] | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // U-type word: imm[31:12] | rd | opcode
  function automatic logic [31:0] enc_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm_hi, rd, op};
  endfunction

endpackage

// File: rtl/rvenc_fifo.sv
// Output FIFO for the instruction encoder: DEPTH x {last, inst}.
// Head valid/data are registered; the next head is computed from the
// post-edge pointers with a bypass so a push into an empty FIFO is visible
// on the very next cycle. Pointers carry one extra wrap bit.
module rvenc_fifo
  import rvenc_pkg::*;
#(
  parameter int unsigned DEPTH = 4  // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_data,
  output logic        full,
  input  logic        pop_ready,
  output logic        head_valid,
  output fifo_entry_t head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        head_valid_q, head_valid_d;
  fifo_entry_t head_data_q, head_data_d;
  fifo_entry_t mem_q [DEPTH];
  logic        pop;

  assign pop  = head_valid_q & pop_ready;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Next pointers and the head entry that will be presented after this edge
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_data_d  = '0;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    head_valid_d = (wr_ptr_d != rd_ptr_d);
    if (head_valid_d) begin
      // The slot being written this edge may already be the new head
      if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
        head_data_d = push_data;
      end else begin
        head_data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Storage array, no reset needed: contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Pointer and registered head state; reset flushes the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs request fields into 32-bit words and
// queues them in an output FIFO with valid/ready on both sides.
// Macro RVENC_LI_SPLIT_EN: when defined, wide LI requests become LUI+ADDI
// through the SPLIT state; when undefined, LI is always a single ADDI and
// an out-of-range LI immediate raises err_range.
module rv32i_inst_encoder
  import rvenc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_op,
  input  logic [2:0]  req_func3,
  input  logic [6:0]  req_func7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        err_range
);

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        rdy_en_q, rdy_en_d;
  logic        accept;
  fmt_e        fmt;
  logic [31:0] enc_inst;
  logic        enc_last;
  logic        enc_err;
  logic        fifo_full;
  logic        fifo_push;
  fifo_entry_t fifo_wdata;
  logic        head_valid;
  fifo_entry_t head_data;
`ifdef RVENC_LI_SPLIT_EN
  logic        enc_split;
  logic [19:0] lui_hi;
  logic [4:0]  split_rd_q, split_rd_d;
  logic [11:0] split_lo_q, split_lo_d;

  // Upper part rounded so that the sign-extended low 12 bits add back exactly
  assign lui_hi = req_imm[31:12] + 20'(req_imm[11]);
`endif

  assign fmt       = fmt_e'(req_fmt);
  // rdy_en_q holds ready low through reset and the first edge after it
  assign req_ready = rdy_en_q & (state_q == ST_IDLE) & ~fifo_full;
  assign accept    = req_valid & req_ready;

  // Field packing and range checking for the request currently presented
  always_comb begin
    enc_inst = '0;
    enc_last = 1'b1;
    enc_err  = 1'b0;
`ifdef RVENC_LI_SPLIT_EN
    enc_split = 1'b0;
`endif
    case (fmt)
      FMT_R: begin
        enc_inst = {req_func7, req_rs2, req_rs1, req_func3, req_rd, req_op};
      end
      FMT_I: begin
        enc_inst = enc_i(req_imm[11:0], req_rs1, req_func3, req_rd, req_op);
        enc_err  = ~imm_fits(req_imm, 12);
      end
      FMT_S: begin
        enc_inst = {req_imm[11:5], req_rs2, req_rs1, req_func3, req_imm[4:0], req_op};
        enc_err  = ~imm_fits(req_imm, 12);
      end
      FMT_B: begin
        enc_inst = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_func3,
                    req_imm[4:1], req_imm[11], req_op};
        enc_err  = ~imm_fits(req_imm, 13) | req_imm[0];
      end
      FMT_U: begin
        enc_inst = enc_u(req_imm[31:12], req_rd, req_op);
      end
      FMT_J: begin
        enc_inst = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_op};
        enc_err  = ~imm_fits(req_imm, 21) | req_imm[0];
      end
      FMT_LI: begin
`ifdef RVENC_LI_SPLIT_EN
        if (imm_fits(req_imm, 12)) begin
          enc_inst = enc_i(req_imm[11:0], REG_X0, F3_ADDI, req_rd, OP_IMM);
        end else begin
          enc_inst = enc_u(lui_hi, req_rd, OP_LUI);
          // A zero low part needs no ADDI; the LUI alone is the whole value
          if (req_imm[11:0] != 12'd0) begin
            enc_last  = 1'b0;
            enc_split = 1'b1;
          end
        end
`else
        enc_inst = enc_i(req_imm[11:0], REG_X0, F3_ADDI, req_rd, OP_IMM);
        enc_err  = ~imm_fits(req_imm, 12);
`endif
      end
      default: begin
        // Reserved code: encode as R-type but flag it
        enc_inst = {req_func7, req_rs2, req_rs1, req_func3, req_rd, req_op};
        enc_err  = 1'b1;
      end
    endcase
  end

  // Control: push on accept, optional SPLIT follow-up push, error pulse
  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    rdy_en_d   = 1'b1;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
`ifdef RVENC_LI_SPLIT_EN
    split_rd_d = split_rd_q;
    split_lo_d = split_lo_q;
`endif
    if (accept) begin
      fifo_push       = 1'b1;
      fifo_wdata.last = enc_last;
      fifo_wdata.inst = enc_inst;
      err_d           = enc_err;
`ifdef RVENC_LI_SPLIT_EN
      if (enc_split) begin
        state_d    = ST_SPLIT;
        split_rd_d = req_rd;
        split_lo_d = req_imm[11:0];
      end
`endif
    end
`ifdef RVENC_LI_SPLIT_EN
    if ((state_q == ST_SPLIT) && !fifo_full) begin
      fifo_push       = 1'b1;
      fifo_wdata.last = 1'b1;
      fifo_wdata.inst = enc_i(split_lo_q, split_rd_q, F3_ADDI, split_rd_q, OP_IMM);
      state_d         = ST_IDLE;
    end
`endif
  end

  // Control state registers; reset aborts any pending SPLIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
`ifdef RVENC_LI_SPLIT_EN
      split_rd_q <= '0;
      split_lo_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rdy_en_q <= rdy_en_d;
`ifdef RVENC_LI_SPLIT_EN
      split_rd_q <= split_rd_d;
      split_lo_q <= split_lo_d;
`endif
    end
  end

  rvenc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (fifo_wdata),
    .full       (fifo_full),
    .pop_ready  (out_ready),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  assign out_valid = head_valid;
  assign out_inst  = head_data.inst;
  assign out_last  = head_data.last;
  assign err_range = err_q;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder; expectations follow RVENC_LI_SPLIT_EN.
module tb_rv32i_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_op;
  logic [2:0]  req_func3;
  logic [6:0]  req_func7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_last;
  logic        err_range;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmt   (req_fmt),
    .req_op    (req_op),
    .req_func3 (req_func3),
    .req_func7 (req_func7),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .err_range (err_range)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one request at the negedge and hold until accepted (bounded);
  // returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int waited = 0;
    @(negedge clk);
    req_fmt = fmt; req_op = op; req_func3 = f3; req_func7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] inst,
                             input logic last, input logic err);
    $display("txn %s: inst=%08h last=%0b err=%0b", tag, out_inst, out_last, err_range);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"},  out_inst, inst);
    chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    chk({tag, "_err"},   {31'd0, err_range}, {31'd0, err});
  endtask

  // With out_ready high the head pops at the next edge; error pulse must end
  task automatic expect_drain(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_errclr"},  {31'd0, err_range}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_fmt = '0; req_op = '0; req_func3 = '0; req_func7 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst",  out_inst, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_err",       {31'd0, err_range}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Formats
    send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add", 32'h002081B3, 1'b1, 1'b0);
    expect_drain("add");
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("sub", 32'h402081B3, 1'b1, 1'b0);
    expect_drain("sub");
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    expect_word("addi_m1", 32'hFFF00293, 1'b1, 1'b0);
    expect_drain("addi_m1");
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd2048);
    expect_word("addi_2048", 32'h80000013, 1'b1, 1'b1);
    expect_drain("addi_2048");
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd31, 5'd1, 5'd2, 32'd8);
    expect_word("beq_8", 32'h00208463, 1'b1, 1'b0);
    expect_drain("beq_8");
    send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7);
    expect_word("beq_7", 32'h00208363, 1'b1, 1'b1);
    expect_drain("beq_7");
    send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    expect_word("sw_m4", 32'hFE20AE23, 1'b1, 1'b0);
    expect_drain("sw_m4");
    send(3'd4, 7'h37, 3'd7, 7'h00, 5'd10, 5'd0, 5'd0, 32'hABCDE123);
    expect_word("lui", 32'hABCDE537, 1'b1, 1'b0);
    expect_drain("lui");
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800);
    expect_word("jal_2048", 32'h001000EF, 1'b1, 1'b0);
    expect_drain("jal_2048");
    send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
    expect_word("jal_odd", 32'h002000EF, 1'b1, 1'b1);
    expect_drain("jal_odd");
    send(3'd7, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("rsv_fmt", 32'h002081B3, 1'b1, 1'b1);
    expect_drain("rsv_fmt");

    // Load-immediate
    send(3'd6, 7'h7F, 3'd7, 7'h00, 5'd6, 5'd0, 5'd0, 32'd100);
    expect_word("li_small", 32'h06400313, 1'b1, 1'b0);
    expect_drain("li_small");
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
`ifdef RVENC_LI_SPLIT_EN
    expect_word("li_lui", 32'h123462B7, 1'b0, 1'b0);
    chk("li_split_busy", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    expect_word("li_addi", 32'hFFF28293, 1'b1, 1'b0);
    chk("li_split_done", {31'd0, req_ready}, 32'd1);
`else
    expect_word("li_big", 32'hFFF00293, 1'b1, 1'b1);
    chk("li_big_ready", {31'd0, req_ready}, 32'd1);
`endif
    expect_drain("li_big");
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
`ifdef RVENC_LI_SPLIT_EN
    expect_word("li_lui_only", 32'h123452B7, 1'b1, 1'b0);
`else
    expect_word("li_lo_zero", 32'h00000293, 1'b1, 1'b1);
`endif
    chk("li_lo_zero_ready", {31'd0, req_ready}, 32'd1);
    expect_drain("li_lo_zero");

    // Backpressure: fill the FIFO, then drain in order
    out_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3);
    send(3'd1, 7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'd4);
    chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    expect_word("bp_head0", 32'h00100093, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_word("bp_head1", 32'h00200113, 1'b1, 1'b0);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    expect_word("bp_head2", 32'h00300193, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    expect_word("bp_head3", 32'h00400213, 1'b1, 1'b0);
    expect_drain("bp");

    // Reset while the ADDI half of a split is still pending
    out_ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
`ifdef RVENC_LI_SPLIT_EN
    expect_word("rst_mid_lui", 32'h123462B7, 1'b0, 1'b0);
`else
    expect_word("rst_mid_addi", 32'hFFF00293, 1'b1, 1'b1);
`endif
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_inst",  out_inst, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mid_err",   {31'd0, err_range}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mid_no_addi", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_still_empty", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready_back",  {31'd0, req_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
